fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
- Owns the program counter and the IF/ID pipeline register of the 16-bit pipelined core.
- Drives the instruction-memory address and captures the fetched word with its PC+2.
- Consumes the branch decision from the branch-condition unit and redirects fetch for B (PC-relative) or BR (register) targets.
- Handles hazard stalls, flushes on a taken branch, and halt draining on HLT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HLT_OPCODE, 4'hF, opcode field (instr[15:12]) that halts fetch
NOP_INSTR, 16'h0000, instruction word inserted into IF/ID on a bubble or flush

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
pc_src  in  1  branch-condition unit: branch in ID is taken
br_reg_sel  in  1  1 = BR (register target), 0 = B (PC-relative target); qualified by pc_src
br_reg_val  in  16  register value for BR target
imem_addr  out  16  current PC, to instruction memory (combinational read)
imem_instr  in  16  instruction word at imem_addr, same cycle
if_id_instr  out  16  registered instruction to ID
if_id_pc_plus2  out  16  registered PC+2 of if_id_instr
if_id_valid  out  1  1 = if_id_instr is a real instruction, 0 = bubble
halted  out  1  sticky: HLT has left IF/ID, fetch stopped

Behaviour:
- Reset (rst_n=0 at a clock edge) values:
  - PC = RESET_PC
  - if_id_instr = NOP_INSTR, if_id_pc_plus2 = 0, if_id_valid = 0
  - halted = 0, state = RUN
  - Reset mid-operation aborts any pending halt or redirect.
- imem_addr = PC, combinational from the PC register.
- pc_plus2 = PC + 2, modulo 2^16: 16'hFFFE wraps to 16'h0000.
- Branch target:
  - B: if_id_pc_plus2 + {sext(if_id_instr[8:0]), 1'b0}, all 16 bits, modulo 2^16, no saturation.
  - BR: br_reg_val, used as-is.
- States: RUN, DRAIN, HALTED.
- Per-cycle priority: reset > stall > redirect > halt > normal.
- stall=1, any state:
  - PC and all IF/ID fields hold. This applies even when pc_src=1: the branch waits in ID.
  - State holds.
- Redirect (stall=0, pc_src=1, state RUN):
  - PC <= target.
  - IF/ID <= {NOP_INSTR, pc_plus2 of current PC, valid=0}. This flushes the wrong-path fetch.
  - A fetched HLT in the same cycle is squashed; state stays RUN.
- HLT fetch (stall=0, pc_src=0, state RUN, imem_instr[15:12]==HLT_OPCODE):
  - PC holds.
  - IF/ID <= {imem_instr, pc_plus2, valid=1}.
  - state <= DRAIN.
- Normal (stall=0, pc_src=0, state RUN, not HLT):
  - PC <= pc_plus2.
  - IF/ID <= {imem_instr, pc_plus2, valid=1}.
- DRAIN:
  - PC holds.
  - On a non-stall cycle: IF/ID <= bubble, state <= HALTED, halted <= 1. pc_src is ignored because ID holds HLT.
- HALTED:
  - PC holds; IF/ID holds the bubble.
  - pc_src and stall are ignored.
  - halted stays 1 until reset.
- Latency:
  - An instruction at address A appears on if_id_instr one cycle after imem_addr==A, absent a stall.
  - Taken-branch penalty is exactly one bubble.
- Every output is driven from registers, except imem_addr, which is a direct copy of the PC register.

Test Plan:
- Reset then free run with imem returning 16'h1234 everywhere:
  - Cycle 1: imem_addr=0000, if_id_valid=0.
  - Cycle 2: if_id_instr=1234, if_id_pc_plus2=0002, valid=1.
  - imem_addr advances 0002, 0004, …
- Taken B with if_id_pc_plus2=0010 and imm=9'h1FC (-4):
  - Next PC = 0010 - 8 = 0008.
  - IF/ID becomes a bubble (valid=0).
  - The following cycle captures the word at 0008.
- Taken BR with br_reg_sel=1, br_reg_val=ABCE:
  - Next imem_addr=ABCE.
  - One bubble; HLT_OPCODE present on imem_instr that same cycle is squashed and halted stays 0.
- stall=1 for 3 cycles while pc_src=1:
  - PC and IF/ID frozen for those 3 cycles.
  - On the first cycle with stall=0, the redirect to the target occurs.
- HLT (16'hF000) fetched at 0006:
  - Next cycle: imem_addr stays 0006, if_id_instr=F000, valid=1.
  - Following cycle: bubble, halted=1.
  - halted stays 1 and PC stays 0006 for 10+ cycles despite pc_src/stall toggling.
  - rst_n=0 then returns PC=RESET_PC and halted=0.
- PC at FFFE, non-branch fetch:
  - Next imem_addr=0000, if_id_pc_plus2=0000.
- B target wrap: if_id_pc_plus2=FFFE, imm=+2:
  - Next PC = 0002.

Source files
------------

// File: rtl/fetch_pc_stage.sv
// Fetch stage of the 16-bit pipelined core: program counter, IF/ID register,
// branch redirect (B / BR), hazard stall and HLT drain handling.
module fetch_pc_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        pc_src,
  input  logic        br_reg_sel,
  input  logic [15:0] br_reg_val,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pp2_q, pp2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2_s;
  logic [15:0] b_target_s;
  logic [15:0] target_s;
  logic        is_hlt_s;

  // Sequential-address, branch-target and HLT-detect datapath.
  always_comb begin
    pc_plus2_s = pc_q + 16'd2;
    // B offset is the sign-extended 9-bit word offset scaled to bytes.
    b_target_s = pp2_q + {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
    if (br_reg_sel) begin
      target_s = br_reg_val;
    end else begin
      target_s = b_target_s;
    end
    is_hlt_s = (imem_instr[15:12] == HLT_OPCODE);
  end

  // Next-state logic: stall > redirect > halt > normal fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pp2_d    = pp2_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      ST_RUN: begin
        if (stall) begin
          state_d = state_q;
        end else if (pc_src) begin
          // Wrong-path fetch (including a HLT) is squashed into a bubble.
          pc_d    = target_s;
          instr_d = NOP_INSTR;
          pp2_d   = pc_plus2_s;
          valid_d = 1'b0;
        end else if (is_hlt_s) begin
          instr_d = imem_instr;
          pp2_d   = pc_plus2_s;
          valid_d = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          pc_d    = pc_plus2_s;
          instr_d = imem_instr;
          pp2_d   = pc_plus2_s;
          valid_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (stall) begin
          state_d = state_q;
        end else begin
          instr_d  = NOP_INSTR;
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State and pipeline registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pp2_q    <= 16'h0000;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pp2_q    <= pp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus2 = pp2_q;
  assign if_id_valid    = valid_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage: each step drives one cycle of inputs and
// queues the expected post-edge outputs, which are popped and checked after the edge.
module tb_fetch_pc_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_src;
  logic        br_reg_sel;
  logic [15:0] br_reg_val;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pp2;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   step  = 0;

  fetch_pc_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .pc_src         (pc_src),
    .br_reg_sel     (br_reg_sel),
    .br_reg_val     (br_reg_val),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $display("FAIL step %0d %s: observed %h expected %h", step, tag, obs, expv);
      $error("step %0d %s observed %h expected %h", step, tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare after the edge.
  task automatic cyc(input logic r, input logic st, input logic ps, input logic sel,
                     input logic [15:0] rv, input logic [15:0] im,
                     input logic [15:0] ea, input logic [15:0] ei, input logic [15:0] ep,
                     input logic ev, input logic eh);
    exp_t e;
    exp_t got;
    rst_n      = r;
    stall      = st;
    pc_src     = ps;
    br_reg_sel = sel;
    br_reg_val = rv;
    imem_instr = im;
    e.addr = ea; e.instr = ei; e.pp2 = ep; e.valid = ev; e.halted = eh;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step++;
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $display("FAIL step %0d scoreboard: observed empty queue expected entry", step);
      $error("scoreboard empty");
    end
    n_cmp--;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      chk("imem_addr", imem_addr, got.addr);
      chk("if_id_instr", if_id_instr, got.instr);
      chk("if_id_pc_plus2", if_id_pc_plus2, got.pp2);
      chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, got.valid});
      chk("halted", {15'd0, halted}, {15'd0, got.halted});
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pc_src = 1'b0; br_reg_sel = 1'b0;
    br_reg_val = 16'h0000; imem_instr = 16'h0000;

    // Reset state
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    // Free run on 1234
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0008, 16'h1234, 16'h0008, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h000A, 16'h1234, 16'h000A, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h000C, 16'h1234, 16'h000C, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h000E, 16'h1234, 16'h000E, 1'b1, 1'b0);
    // Branch word with imm 1FC captured, pc_plus2 = 0010
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hC1FC, 16'h0010, 16'hC1FC, 16'h0010, 1'b1, 1'b0);
    // Taken B: 0010 - 8 = 0008, one bubble
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0008, 16'h0000, 16'h0012, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555, 16'h000A, 16'h5555, 16'h000A, 1'b1, 1'b0);
    // Taken BR to ABCE, HLT on imem squashed
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hABCE, 16'hF000, 16'hABCE, 16'h0000, 16'h000C, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'hABD0, 16'h1234, 16'hABD0, 1'b1, 1'b0);
    // Stall 3 cycles with pc_src high: everything frozen
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777, 16'hABD0, 16'h1234, 16'hABD0, 1'b1, 1'b0);
    end
    // Stall released: B target ABD0 + 0x68 = AC38
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7777, 16'hAC38, 16'h0000, 16'hABD2, 1'b0, 1'b0);
    // BR to FFFC, then fetch across the top of memory
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 16'h7777, 16'hFFFC, 16'h0000, 16'hAC3A, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h0000, 1'b1, 1'b0);
    // B wrap: pc_plus2 FFFE, imm +2 -> 0002
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFC, 16'h7777, 16'hFFFC, 16'h0000, 16'h0002, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'hFFFE, 16'h0002, 16'hFFFE, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b0);
    // Run to 0006 and fetch HLT there
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hF000, 16'h0006, 16'hF000, 16'h0008, 1'b1, 1'b0);
    // Stall while draining holds HLT in IF/ID
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0006, 16'hF000, 16'h0008, 1'b1, 1'b0);
    // Drain completes; pc_src ignored
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h4444, 16'h1234, 16'h0006, 16'h0000, 16'h0008, 1'b0, 1'b1);
    // Halted: toggle stall/pc_src for 12 cycles
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, i[0], i[1], i[2], 16'h1111, 16'h1234,
          16'h0006, 16'h0000, 16'h0008, 1'b0, 1'b1);
    end
    // Reset clears halt, then fetch resumes from RESET_PC
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
